// File: rtl/pipe_pkg.sv
// Shared fetch-path definitions: instruction width, PC increment and the
// prefetch queue entry layout.
package pipe_pkg;

    localparam int INST_W   = 32;
    localparam int PC_INC   = 4;
    localparam int PC_MAX_W = 64;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    // pc_plus4 is sized for the widest core; narrower cores zero-extend into it.
    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [PC_MAX_W-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with a registered storage array, synchronous clear and an
// occupancy output. DEPTH must be a power of two so the pointers wrap freely.
module inst_fifo #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push = push && (count != CW'(DEPTH));
        do_pop  = pop && (count != '0);
    end

    assign rdata = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= wdata;
                tail      <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: PC generation, single-outstanding memory request
// tracking with stale-response discard on redirect, and a prefetch queue to ID.
module fetch_prefetch_unit
    import pipe_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imemReq,
    output logic [XLEN-1:0]            imemAddr,
    input  logic                       imemRvalid,
    input  logic [INST_W-1:0]          imemRdata,
    input  logic                       redirectValid,
    input  logic [XLEN-1:0]            redirectPc,
    output logic                       idValid,
    output logic [INST_W-1:0]          idInst,
    output logic [XLEN-1:0]            idPcPlus4,
    input  logic                       idReady,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = CW + 1;
    localparam fetch_entry_t RESET_ENTRY = '{inst: NOP_INST, pc_plus4: '0};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] req_pc_plus4;
    logic            outstanding;
    logic            stale;

    logic            resp;
    logic            issue;
    logic            push;
    logic            pop;
    logic [IW-1:0]   inflight;
    fetch_entry_t    wr_entry;
    fetch_entry_t    rd_entry;

    // Request side: occupancy plus the in-flight fetch must leave room for its response.
    always_comb begin
        pc_next  = fetch_pc + XLEN'(PC_INC);
        resp     = imemRvalid && outstanding;
        inflight = IW'(count) + IW'(outstanding);
        issue    = !rst && !redirectValid && (!outstanding || imemRvalid)
                   && (inflight < IW'(DEPTH));
        push     = resp && !stale && !redirectValid;
        idValid  = (count != '0) && !redirectValid;
        pop      = idValid && idReady;

        wr_entry.inst     = imemRdata;
        wr_entry.pc_plus4 = PC_MAX_W'(req_pc_plus4);

        imemReq   = issue;
        imemAddr  = fetch_pc;
        idInst    = rd_entry.inst;
        idPcPlus4 = XLEN'(rd_entry.pc_plus4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            stale       <= 1'b0;
        end else if (redirectValid) begin
            // A fetch still in flight belongs to the old path; mark it for discard.
            fetch_pc    <= redirectPc;
            outstanding <= outstanding && !imemRvalid;
            stale       <= outstanding && !imemRvalid;
        end else begin
            if (issue) begin
                fetch_pc    <= pc_next;
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
            if (resp && stale) begin
                stale <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc_plus4 <= pc_next;
        end
    end

    inst_fifo #(
        .WIDTH     ($bits(fetch_entry_t)),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_ENTRY)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirectValid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a variable-latency memory model, a
// scoreboard of expected ID-stage entries and a monitor that checks every pop.
module tb_fetch_prefetch_unit;

    localparam int          XLEN  = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h100;

    logic              clk;
    logic              rst;
    logic              imemReq;
    logic [XLEN-1:0]   imemAddr;
    logic              imemRvalid;
    logic [31:0]       imemRdata;
    logic              redirectValid;
    logic [XLEN-1:0]   redirectPc;
    logic              idValid;
    logic [31:0]       idInst;
    logic [XLEN-1:0]   idPcPlus4;
    logic              idReady;
    logic [2:0]        count;

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemRvalid    (imemRvalid),
        .imemRdata     (imemRdata),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .idValid       (idValid),
        .idInst        (idInst),
        .idPcPlus4     (idPcPlus4),
        .idReady       (idReady),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 1;

    function automatic logic [31:0] memw(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic expect_pop(input logic [63:0] addr, input logic [63:0] pc4);
        exp_t e;
        e.inst = memw(addr);
        e.pc4  = pc4;
        exp_q.push_back(e);
    endtask

    // In-order memory: a request seen this cycle answers lat cycles later.
    task automatic mem_loop();
        logic        pend_valid = 1'b0;
        logic [63:0] pend_addr  = '0;
        int          pend_left  = 0;
        forever begin
            @(negedge clk);
            imemRvalid = 1'b0;
            imemRdata  = '0;
            if (pend_valid) begin
                pend_left--;
                if (pend_left == 0) begin
                    imemRvalid = 1'b1;
                    imemRdata  = memw(pend_addr);
                    pend_valid = 1'b0;
                end
            end
            #3;
            if (imemReq) begin
                pend_valid = 1'b1;
                pend_addr  = imemAddr;
                pend_left  = lat;
            end
        end
    endtask

    task automatic mon_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (idValid && idReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got inst %h pc4 %h, want no pop", idInst, idPcPlus4);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_inst", {32'h0, idInst}, {32'h0, e.inst});
                    check("pop_pc4", idPcPlus4, e.pc4);
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        cyc();
        rst     = 1'b1;
        idReady = 1'b0;
        repeat (n - 1) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        idReady       = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        imemRvalid    = 1'b0;
        imemRdata     = '0;
        fork
            mem_loop();
            mon_loop();
        join_none

        // Reset state
        repeat (3) cyc();
        #1;
        check("rst_req", {63'h0, imemReq}, 64'h0);
        check("rst_addr", imemAddr, 64'h100);
        check("rst_valid", {63'h0, idValid}, 64'h0);
        check("rst_inst", {32'h0, idInst}, 64'h0);
        check("rst_pc4", idPcPlus4, 64'h0);
        check("rst_count", {61'h0, count}, 64'h0);

        // Streaming with 1-cycle memory, then back-pressure to a full queue
        for (int i = 0; i < 8; i++) expect_pop(64'h100 + 64'(4 * i), 64'h104 + 64'(4 * i));
        cyc(); rst = 1'b0; idReady = 1'b1; #1;
        check("s1_req0", {63'h0, imemReq}, 64'h1);
        check("s1_addr0", imemAddr, 64'h100);
        cyc(); #1;
        check("s1_addr1", imemAddr, 64'h104);
        check("s1_novalid", {63'h0, idValid}, 64'h0);
        cyc(); #1;
        check("s1_addr2", imemAddr, 64'h108);
        check("s1_valid2", {63'h0, idValid}, 64'h1);
        repeat (3) cyc();
        cyc(); idReady = 1'b0;
        repeat (2) cyc();
        cyc(); #1;
        check("s2_req_held", {63'h0, imemReq}, 64'h0);
        cyc(); #1;
        check("s2_count_full", {61'h0, count}, 64'h4);
        check("s2_req_full", {63'h0, imemReq}, 64'h0);
        cyc(); idReady = 1'b1; #1;
        check("s2_req_still_full", {63'h0, imemReq}, 64'h0);
        cyc(); #1;
        check("s2_resume_req", {63'h0, imemReq}, 64'h1);
        check("s2_resume_addr", imemAddr, 64'h120);
        repeat (2) cyc();
        cyc(); idReady = 1'b0;
        cyc(); #1;
        check("s1_drain", 64'(exp_q.size()), 64'h0);

        // 3-cycle memory, redirect while 0x108 is in flight
        lat = 3;
        do_reset(4);
        expect_pop(64'h100, 64'h104);
        expect_pop(64'h104, 64'h108);
        expect_pop(64'h200, 64'h204);
        cyc(); rst = 1'b0; idReady = 1'b1;
        repeat (7) cyc();
        cyc(); redirectValid = 1'b1; redirectPc = 64'h200; #1;
        check("s3_redir_noreq", {63'h0, imemReq}, 64'h0);
        cyc(); redirectValid = 1'b0; #1;
        check("s3_req_stale_cyc", {63'h0, imemReq}, 64'h1);
        check("s3_addr_stale_cyc", imemAddr, 64'h200);
        cyc(); #1;
        check("s3_stale_dropped", {61'h0, count}, 64'h0);
        repeat (3) cyc();
        cyc(); idReady = 1'b0;
        cyc(); #1;
        check("s3_drain", 64'(exp_q.size()), 64'h0);

        // Redirect coincident with a response and a ready ID stage
        lat = 1;
        do_reset(4);
        expect_pop(64'h300, 64'h304);
        cyc(); rst = 1'b0; idReady = 1'b1;
        cyc();
        cyc(); redirectValid = 1'b1; redirectPc = 64'h300; #1;
        check("s4_valid_masked", {63'h0, idValid}, 64'h0);
        check("s4_redir_noreq", {63'h0, imemReq}, 64'h0);
        check("s4_count_before", {61'h0, count}, 64'h1);
        cyc(); redirectValid = 1'b0; #1;
        check("s4_count_cleared", {61'h0, count}, 64'h0);
        check("s4_req", {63'h0, imemReq}, 64'h1);
        check("s4_addr", imemAddr, 64'h300);
        cyc();
        cyc();
        cyc(); idReady = 1'b0;
        cyc(); #1;
        check("s4_drain", 64'(exp_q.size()), 64'h0);

        // Reset with a fetch outstanding; the late response must be ignored
        lat = 2;
        do_reset(4);
        expect_pop(64'h100, 64'h104);
        cyc(); rst = 1'b0; idReady = 1'b1;
        cyc(); rst = 1'b1; #1;
        check("s5_rst_noreq", {63'h0, imemReq}, 64'h0);
        cyc(); rst = 1'b0; #1;
        check("s5_restart_req", {63'h0, imemReq}, 64'h1);
        check("s5_restart_addr", imemAddr, 64'h100);
        cyc(); #1;
        check("s5_no_spurious", {61'h0, count}, 64'h0);
        check("s5_wait_req", {63'h0, imemReq}, 64'h0);
        cyc();
        cyc();
        cyc(); idReady = 1'b0;
        cyc(); #1;
        check("s5_drain", 64'(exp_q.size()), 64'h0);

        // 64-bit PC wrap
        lat = 1;
        do_reset(4);
        expect_pop(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
        cyc(); rst = 1'b0;
        cyc();
        cyc(); redirectValid = 1'b1; redirectPc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(); redirectValid = 1'b0; #1;
        check("s6_req", {63'h0, imemReq}, 64'h1);
        check("s6_addr_top", imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(); #1;
        check("s6_addr_wrap", imemAddr, 64'h0);
        cyc(); idReady = 1'b1; #1;
        check("s6_pc4_wrap", idPcPlus4, 64'h0);
        cyc(); idReady = 1'b0;
        repeat (3) cyc();
        check("s6_drain", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
